// File: rtl/fcmp_pkg.sv
// Shared definitions for the two-requester float compare arbiter.
// FCMP_IEEE_SPECIAL_EN selects IEEE NaN/zero handling in fcmp_core.
package fcmp_pkg;

  typedef enum logic [1:0] {
    OP_FEQ = 2'b00,
    OP_FLT = 2'b01,
    OP_FLE = 2'b10,
    OP_RSV = 2'b11
  } fcmp_op_e;

  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

  // Exponent all ones with a nonzero mantissa.
  function automatic logic is_nan(input logic [31:0] v);
    return (&v[30:23]) && (|v[22:0]);
  endfunction

  function automatic logic is_zero(input logic [31:0] v);
    return ~(|v[30:0]);
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational single-precision compare (feq/flt/fle; reserved op yields 0).
// FCMP_IEEE_SPECIAL_EN: NaN makes every op false and +0 equals -0.
module fcmp_core (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [1:0]  op,
  output logic        y
);
  import fcmp_pkg::*;

  logic lt;
  logic eq;
  logic unordered;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    lt        = 1'b0;
    eq        = (x1 == x2);
    unordered = 1'b0;

    if (x1[31] != x2[31]) begin
      lt = x1[31];
    end else if (!x1[31]) begin
      lt = (x1[30:0] < x2[30:0]);
    end else begin
      lt = (x1[30:0] > x2[30:0]);
    end

`ifdef FCMP_IEEE_SPECIAL_EN
    unordered = is_nan(x1) || is_nan(x2);
    if (is_zero(x1) && is_zero(x2)) begin
      lt = 1'b0;
      eq = 1'b1;
    end
`endif
  end

  always_comb begin
    y = 1'b0;
    if (!unordered) begin
      case (fcmp_op_e'(op))
        OP_FEQ:  y = eq;
        OP_FLT:  y = lt;
        OP_FLE:  y = lt | eq;
        default: y = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fcmp_arbiter.sv
// Two requesters share one float comparator through a 2-stage pipeline
// (S1 operands, S2 result). FCMP_IEEE_SPECIAL_EN is forwarded to fcmp_core.
module fcmp_arbiter #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [31:0]      req0_x1,
  input  logic [31:0]      req0_x2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [31:0]      req1_x1,
  input  logic [31:0]      req1_x2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_y,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag
);
  import fcmp_pkg::*;

  logic             rr_ptr;
  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [31:0]      s1_x1;
  logic [31:0]      s1_x2;
  logic             s1_src;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             take;
  logic             sel;
  logic             core_y;

  assign s2_adv = ~s2_valid | rsp_ready;
  assign s1_adv = ~s1_valid | s2_adv;

  // Round-robin only matters when both ask; a lone requester always wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rstn && s1_adv) begin
      if (req0_valid && req1_valid) begin
        if (rr_ptr == SRC_REQ1) req1_ready = 1'b1;
        else                    req0_ready = 1'b1;
      end else if (req0_valid) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  assign take = req0_ready | req1_ready;
  assign sel  = req1_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      rr_ptr   <= SRC_REQ0;
    end else begin
      if (s1_adv) s1_valid <= take;
      if (take)   rr_ptr   <= req0_ready;
    end
  end

  // NOTE: payload registers carry no reset; s1_valid qualifies their contents.
  always_ff @(posedge clk) begin
    if (take) begin
      s1_op  <= sel ? req1_op  : req0_op;
      s1_x1  <= sel ? req1_x1  : req0_x1;
      s1_x2  <= sel ? req1_x2  : req0_x2;
      s1_tag <= sel ? req1_tag : req0_tag;
      s1_src <= sel ? SRC_REQ1 : SRC_REQ0;
    end
  end

  fcmp_core u_core (
    .x1 (s1_x1),
    .x2 (s1_x2),
    .op (s1_op),
    .y  (core_y)
  );

  // Result is evaluated from S1 alone during the S1->S2 transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      rsp_y    <= 1'b0;
      rsp_src  <= 1'b0;
      rsp_tag  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        rsp_y   <= core_y;
        rsp_src <= s1_src;
        rsp_tag <= s1_tag;
      end
    end
  end

  assign rsp_valid = s2_valid;

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Self-checking bench for fcmp_arbiter: queue-based reference model plus directed
// literal checks. Define FCMP_IEEE_SPECIAL_EN for both RTL and bench to test that mode.
module tb_fcmp_arbiter;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [1:0]       req0_op, req1_op;
  logic [31:0]      req0_x1, req0_x2, req1_x1, req1_x2;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp_valid, rsp_ready, rsp_y, rsp_src;
  logic [TAG_W-1:0] rsp_tag;

  int n_cmp  = 0;
  int n_fail = 0;

  fcmp_arbiter #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_x1    (req0_x1),
    .req0_x2    (req0_x2),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_x1    (req1_x1),
    .req1_x2    (req1_x2),
    .req1_tag   (req1_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_src    (rsp_src),
    .rsp_tag    (rsp_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Order floats by mapping sign-magnitude bits onto a signed integer line.
  function automatic longint order_key(input logic [31:0] v);
    longint mag;
    mag = longint'(v[30:0]);
    return v[31] ? (-mag - 1) : mag;
  endfunction

  function automatic logic model_y(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ka, kb;
    ka = order_key(a);
    kb = order_key(b);
`ifdef FCMP_IEEE_SPECIAL_EN
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 1'b0;
    if (a[30:0] == 0) ka = 0;
    if (b[30:0] == 0) kb = 0;
`endif
    case (op)
      2'b00:   return ka == kb;
      2'b01:   return ka < kb;
      2'b10:   return ka <= kb;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic             y;
    logic             src;
    logic [TAG_W-1:0] tag;
    int               stage;
  } item_t;

  // Reference: in-flight items in arrival order, each in stage 1 or 2.
  initial begin
    item_t pipe[$];
    item_t it;
    bit    m_ptr;
    bit    s1_occ, s2_occ, s2_adv, s1_adv, g0, g1;
    m_ptr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pipe.delete();
        m_ptr = 1'b0;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_valid",  rsp_valid,  0);
        check("rst_y",      rsp_y,      0);
        check("rst_src",    rsp_src,    0);
        check("rst_tag",    rsp_tag,    0);
      end else begin
        s2_occ = (pipe.size() > 0) && (pipe[0].stage == 2);
        s1_occ = (pipe.size() > 0) && (pipe[pipe.size()-1].stage == 1);
        s2_adv = !s2_occ || rsp_ready;
        s1_adv = !s1_occ || s2_adv;
        g0 = 1'b0;
        g1 = 1'b0;
        if (s1_adv) begin
          if (req0_valid && req1_valid) begin
            if (m_ptr) g1 = 1'b1;
            else       g0 = 1'b1;
          end else begin
            g0 = req0_valid;
            g1 = req1_valid;
          end
        end
        check("m_ready0", req0_ready, g0);
        check("m_ready1", req1_ready, g1);
        check("m_rsp_valid", rsp_valid, s2_occ);
        if (s2_occ) begin
          check("m_rsp_y",   rsp_y,   pipe[0].y);
          check("m_rsp_src", rsp_src, pipe[0].src);
          check("m_rsp_tag", rsp_tag, pipe[0].tag);
        end
        if (s2_occ && rsp_ready) void'(pipe.pop_front());
        if (pipe.size() > 0 && pipe[0].stage == 1) pipe[0].stage = 2;
        if (g0 || g1) begin
          it.y     = g1 ? model_y(req1_op, req1_x1, req1_x2) : model_y(req0_op, req0_x1, req0_x2);
          it.src   = g1;
          it.tag   = g1 ? req1_tag : req0_tag;
          it.stage = 1;
          pipe.push_back(it);
          m_ptr = g0;
        end
      end
    end
  end

  task automatic drive0(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t);
    req0_valid = v; req0_op = op; req0_x1 = a; req0_x2 = b; req0_tag = t;
  endtask

  task automatic drive1(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t);
    req1_valid = v; req1_op = op; req1_x1 = a; req1_x2 = b; req1_tag = t;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  // Single req0 transaction; result must appear two cycles after acceptance.
  task automatic cmp_one(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t, input logic exp);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drive0(1'b1, op, a, b, t);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check({name, "_early"}, rsp_valid, 0);
    @(posedge clk); #1;
    check({name, "_valid"}, rsp_valid, 1);
    check({name, "_y"},     rsp_y,     exp);
    check({name, "_src"},   rsp_src,   0);
    check({name, "_tag"},   rsp_tag,   t);
  endtask

  initial begin
    rstn = 1'b0;
    rsp_ready = 1'b1;
    drive0(1'b1, 2'b00, 32'h0, 32'h0, '0);
    drive1(1'b0, 2'b00, 32'h0, 32'h0, '0);
    idle(2); #1;
    check("reset_ready0", req0_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    req0_valid = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;

    cmp_one("fle_1_2", 2'b10, 32'h3F800000, 32'h40000000, 5'd3, 1'b1);
    cmp_one("flt_neg", 2'b01, 32'hBF800000, 32'h80000000, 5'd4, 1'b1);
`ifdef FCMP_IEEE_SPECIAL_EN
    cmp_one("feq_zero", 2'b00, 32'h80000000, 32'h00000000, 5'd5, 1'b1);
    cmp_one("flt_zero", 2'b01, 32'h80000000, 32'h00000000, 5'd6, 1'b0);
    cmp_one("feq_nan",  2'b00, 32'h7FC00000, 32'h7FC00000, 5'd7, 1'b0);
`else
    cmp_one("feq_zero", 2'b00, 32'h80000000, 32'h00000000, 5'd5, 1'b0);
    cmp_one("flt_zero", 2'b01, 32'h80000000, 32'h00000000, 5'd6, 1'b1);
    cmp_one("feq_nan",  2'b00, 32'h7FC00000, 32'h7FC00000, 5'd7, 1'b1);
`endif
    cmp_one("rsv_op",   2'b11, 32'h3F800000, 32'h3F800000, 5'd8, 1'b0);
    cmp_one("flt_pos",  2'b01, 32'h40000000, 32'h3F800000, 5'd9, 1'b0);
    cmp_one("fle_nn",   2'b10, 32'hC0000000, 32'hBF800000, 5'd10, 1'b1);

    // Round-robin from reset: grants 0,1,0,1,... and one result per cycle.
    @(posedge clk); #2;
    rstn = 1'b0;
    rsp_ready = 1'b1;
    drive0(1'b1, 2'b01, 32'h3F800000, 32'h40000000, 5'd1);
    drive1(1'b1, 2'b00, 32'h3F800000, 32'h40000000, 5'd2);
    @(posedge clk); #2;
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_grant0", req0_ready, (k % 2) == 0);
      check("rr_grant1", req1_ready, (k % 2) == 1);
      if (k >= 2) begin
        check("rr_rsp_valid", rsp_valid, 1);
        check("rr_rsp_src",   rsp_src,   (k - 2) % 2);
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    idle(4);

    // Backpressure: fill both stages, hold the head, then drain in order.
    #1;
    rsp_ready = 1'b0;
    drive0(1'b1, 2'b01, 32'hBF800000, 32'h3F800000, 5'd10);
    drive1(1'b1, 2'b01, 32'h3F800000, 32'hBF800000, 5'd20);
    idle(5); #1;
    check("stall_ready0", req0_ready, 0);
    check("stall_ready1", req1_ready, 0);
    check("stall_valid",  rsp_valid,  1);
    check("stall_tag",    rsp_tag,    10);
    check("stall_y",      rsp_y,      1);
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_valid", rsp_valid, 1);
    check("drain_tag",   rsp_tag,   20);
    check("drain_y",     rsp_y,     0);
    @(posedge clk); #1;
    check("drain_empty", rsp_valid, 0);
    idle(2);

    // Reset with both stages full and pointer on req1.
    #1;
    rsp_ready = 1'b0;
    drive0(1'b1, 2'b10, 32'h3F800000, 32'h3F800000, 5'd12);
    idle(4); #1;
    check("prerst_full", rsp_valid, 1);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst_valid",  rsp_valid,  0);
    check("midrst_ready0", req0_ready, 0);
    check("midrst_tag",    rsp_tag,    0);
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("postrst_no_stale", rsp_valid, 0);
    end
    drive0(1'b1, 2'b00, 32'h1, 32'h1, 5'd13);
    drive1(1'b1, 2'b00, 32'h1, 32'h2, 5'd14);
    @(negedge clk);
    check("postrst_ptr0", req0_ready, 1);
    check("postrst_ptr1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fcmp_arbiter.md
FCMP_ARBITER -- requirements
Module: fcmp_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 5, width of the requester destination tag.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N presents a compare.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester N accepted this cycle.
REQ-006 SHALL have ports req0_op / req1_op  input  2  00 feq, 01 flt, 10 fle, 11 reserved.
REQ-007 SHALL have ports req0_x1, req0_x2, req1_x1, req1_x2  input  32  IEEE-754 single operands.
REQ-008 SHALL have ports req0_tag / req1_tag  input  TAG_W  returned unchanged with the result.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-011 SHALL have port rsp_y  output  1  compare outcome.
REQ-012 SHALL have port rsp_src  output  1  originating requester (0/1).
REQ-013 SHALL have port rsp_tag  output  TAG_W  tag of originating request.

Function
REQ-014 SHALL share one comparator between two requesters through a 2-stage pipeline: S1 operand/op/src/tag register, S2 result register driving rsp_*.
REQ-015 SHALL transfer a request when reqN_valid and reqN_ready are both high at a rising edge; reqN_ready SHALL be combinational from valids, round-robin pointer, pipeline state and rsp_ready.
REQ-016 SHALL compute s2_adv = ~s2_valid | rsp_ready and s1_adv = ~s1_valid | s2_adv; no requester gets ready when s1_adv is low.
REQ-017 SHALL, with s1_adv high and exactly one valid, grant that requester regardless of pointer.
REQ-018 SHALL, with both valid, grant the requester named by the 1-bit round-robin pointer; after any grant the pointer SHALL point to the non-granted side.
REQ-019 SHALL never assert both req0_ready and req1_ready in one cycle.
REQ-020 SHALL assert rsp_valid two cycles after the accepting cycle when unstalled; throughput one result per cycle.
REQ-021 SHALL hold rsp_y/rsp_src/rsp_tag stable while rsp_valid & ~rsp_ready; S1 SHALL hold if occupied; no result SHALL be lost or duplicated.
REQ-022 SHALL compare sign-magnitude: both positive -> magnitude order; negative vs positive -> negative is less; both negative -> larger magnitude is less; identical bits -> equal.
REQ-023 SHALL return rsp_y = 0 for op 11.
REQ-024 SHALL evaluate the comparison in the S1->S2 transfer cycle from S1 contents only.

Reset
REQ-025 SHALL, while rstn low, force s1_valid=0, s2_valid=0, rsp_valid=0, rsp_y=0, rsp_src=0, rsp_tag=0, pointer=0, reqN_ready=0.
REQ-026 SHALL discard in-flight requests on reset mid-operation; requesters re-issue.
REQ-027 SHALL resume accepting on the first rising edge after rstn deasserts.

Configuration
REQ-028 SHALL, with FCMP_IEEE_SPECIAL_EN defined, return 0 for any op when either operand is NaN (exp all ones, mantissa nonzero) and treat +0 and -0 as equal.
REQ-029 SHALL, without FCMP_IEEE_SPECIAL_EN, use pure sign-magnitude ordering per REQ-022 (NaN ordered by bits, -0 < +0).

Structure
REQ-030 SHALL place op encodings (OP_FEQ, OP_FLT, OP_FLE, OP_RSV) and source IDs in shared package fcmp_pkg.
REQ-031 SHALL instantiate one combinational sub-module fcmp_core (x1, x2, op -> y) containing REQ-022/023/028/029 logic.

Verification
REQ-032 SHALL check: req0 fle 0x3F800000,0x40000000 tag 3, rsp_ready=1 -> rsp_y=1, rsp_src=0, rsp_tag=3 two cycles later.
REQ-033 SHALL check: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 after reset; one result per cycle.
REQ-034 SHALL check: flt 0xBF800000,0x80000000 -> 1; feq 0x80000000,0x00000000 -> 1 with macro, 0 without; flt 0x80000000,0x00000000 -> 0 with macro, 1 without.
REQ-035 SHALL check: feq 0x7FC00000,0x7FC00000 -> 0 with macro, 1 without; op 11 any operands -> 0.
REQ-036 SHALL check: rsp_ready low 5 cycles with both requesters valid -> S1,S2 fill, readies low, rsp held; release -> both results delivered in order.
REQ-037 SHALL check: rstn pulsed low with S1,S2 full -> rsp_valid=0 immediately, pointer=0, no stale result after release.
